// File: rtl/accum_frame_ctrl_if.sv
// rtl/accum_frame_ctrl_if.sv - command, sample stream and result stream bundle for accum_frame_ctrl
interface accum_frame_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 40,
    parameter int LW = 16
);
    logic          start;
    logic [LW-1:0] frame_len;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in1;
    logic [DW-1:0] in2;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic          busy;
    logic          err_len0;

    modport master (
        output start, frame_len, abort, in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, out_data, busy, err_len0
    );

    modport slave (
        input  start, frame_len, abort, in_valid, in1, in2, out_ready,
        output in_ready, out_valid, out_data, busy, err_len0
    );
endinterface

// File: rtl/accum_frame_ctrl.sv
// rtl/accum_frame_ctrl.sv - frame sequencer around a cross-coupled dual accumulator
module accum_frame_ctrl #(
    parameter int DW = 32,
    parameter int AW = 40,
    parameter int LW = 16
) (
    input  logic               clk,
    input  logic               rst,
    accum_frame_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

    state_t        state;
    logic [LW-1:0] len;
    logic [LW-1:0] count;
    logic [AW-1:0] acc0;
    logic [AW-1:0] acc1;

    logic beat;
    assign beat = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            len           <= '0;
            count         <= '0;
            acc0          <= '0;
            acc1          <= '0;
            bus.out_data  <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.err_len0  <= 1'b0;
        end else begin
            bus.err_len0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.frame_len != '0) begin
                            len          <= bus.frame_len;
                            count        <= '0;
                            acc0         <= '0;
                            acc1         <= '0;
                            state        <= RUN;
                            bus.in_ready <= 1'b1;
                            bus.busy     <= 1'b1;
                        end else begin
                            bus.err_len0 <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // abort outranks a coincident beat, which is dropped
                    if (bus.abort) begin
                        state        <= IDLE;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b0;
                    end else if (beat) begin
                        acc0  <= acc1 + AW'(bus.in1);
                        acc1  <= acc0 + AW'(bus.in2);
                        count <= count + LW'(1);
                        if (count == len - LW'(1)) begin
                            state        <= FINAL;
                            bus.in_ready <= 1'b0;
                        end
                    end
                end
                FINAL: begin
                    if (bus.abort) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        bus.out_data  <= acc0 + acc1;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready || bus.abort) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_accum_frame_ctrl.sv
// tb/tb_accum_frame_ctrl.sv - directed self-checking bench for accum_frame_ctrl
module tb_accum_frame_ctrl;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    accum_frame_ctrl_if #(.DW(32), .AW(40), .LW(16)) b ();
    accum_frame_ctrl_if #(.DW(32), .AW(33), .LW(16)) b33 ();

    accum_frame_ctrl #(.DW(32), .AW(40), .LW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    accum_frame_ctrl #(.DW(32), .AW(33), .LW(16)) dut33 (
        .clk (clk),
        .rst (rst),
        .bus (b33.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] n);
        b.start = 1'b1;
        b.frame_len = n;
        tick();
        b.start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] c);
        b.in_valid = 1'b1;
        b.in1 = a;
        b.in2 = c;
        tick();
        b.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({b.in_ready, b.out_valid, b.busy, b.err_len0} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags got=%b want=0000", {b.in_ready, b.out_valid, b.busy, b.err_len0});
        end
        tests_run++;
        if (b.out_data !== 40'd0) begin
            tests_failed++;
            $display("FAIL reset_out_data got=%0h want=0", b.out_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        start_frame(16'd1);
        tests_run++;
        if (b.in_ready !== 1'b1 || b.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_run_entry in_ready=%b busy=%b want 1 1", b.in_ready, b.busy);
        end
        beat(32'd5, 32'd7);
        tests_run++;
        if (b.in_ready !== 1'b0 || b.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_final in_ready=%b out_valid=%b want 0 0", b.in_ready, b.out_valid);
        end
        tick();
        tests_run++;
        if (b.out_valid !== 1'b1 || b.out_data !== 40'd12) begin
            tests_failed++;
            $display("FAIL single_result out_valid=%b out_data=%0d want 1 12", b.out_valid, b.out_data);
        end
        b.out_ready = 1'b1;
        tick();
        b.out_ready = 1'b0;
        tests_run++;
        if (b.out_valid !== 1'b0 || b.busy !== 1'b0 || b.out_data !== 40'd12) begin
            tests_failed++;
            $display("FAIL single_after_hs out_valid=%b busy=%b out_data=%0d want 0 0 12", b.out_valid, b.busy, b.out_data);
        end
    endtask

    task automatic test_gaps();
        start_frame(16'd3);
        beat(32'd1, 32'd2);
        tick();
        beat(32'd3, 32'd4);
        tick();
        beat(32'd5, 32'd6);
        b.out_ready = 1'b1;
        tests_run++;
        if (b.out_valid !== 1'b0 || b.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL gaps_final out_valid=%b in_ready=%b want 0 0", b.out_valid, b.in_ready);
        end
        tick();
        tests_run++;
        if (b.out_valid !== 1'b1 || b.out_data !== 40'd21) begin
            tests_failed++;
            $display("FAIL gaps_result out_valid=%b out_data=%0d want 1 21", b.out_valid, b.out_data);
        end
        tick();
        b.out_ready = 1'b0;
        tests_run++;
        if (b.out_valid !== 1'b0 || b.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL gaps_immediate_hs out_valid=%b busy=%b want 0 0", b.out_valid, b.busy);
        end
    endtask

    task automatic test_wrap();
        b33.start = 1'b1;
        b33.frame_len = 16'd2;
        tick();
        b33.start = 1'b0;
        b33.in_valid = 1'b1;
        b33.in1 = 32'hFFFF_FFFF;
        b33.in2 = 32'hFFFF_FFFF;
        tick();
        tick();
        b33.in_valid = 1'b0;
        tick();
        tests_run++;
        if (b33.out_valid !== 1'b1 || b33.out_data !== 33'h1_FFFF_FFFC) begin
            tests_failed++;
            $display("FAIL wrap_aw33 out_valid=%b out_data=%0h want 1 1fffffffc", b33.out_valid, b33.out_data);
        end
        b33.out_ready = 1'b1;
        tick();
        b33.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        start_frame(16'd2);
        beat(32'd10, 32'd20);
        beat(32'd30, 32'd40);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (b.out_valid !== 1'b1 || b.out_data !== 40'd100) bad++;
            if (i == 1) begin
                b.start = 1'b1;
                b.frame_len = 16'd3;
            end else begin
                b.start = 1'b0;
            end
            tick();
        end
        b.start = 1'b0;
        tests_run++;
        if (bad != 0 || b.out_valid !== 1'b1 || b.out_data !== 40'd100) begin
            tests_failed++;
            $display("FAIL bp_hold bad_cycles=%0d out_valid=%b out_data=%0d want 0 1 100", bad, b.out_valid, b.out_data);
        end
        b.out_ready = 1'b1;
        tick();
        b.out_ready = 1'b0;
        tests_run++;
        if (b.out_valid !== 1'b0 || b.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release out_valid=%b busy=%b want 0 0", b.out_valid, b.busy);
        end
        tick();
        tests_run++;
        if (b.in_ready !== 1'b0 || b.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_start_ignored in_ready=%b busy=%b want 0 0", b.in_ready, b.busy);
        end
    endtask

    task automatic test_len0();
        start_frame(16'd0);
        tests_run++;
        if (b.err_len0 !== 1'b1 || b.busy !== 1'b0 || b.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL len0_pulse err=%b busy=%b in_ready=%b want 1 0 0", b.err_len0, b.busy, b.in_ready);
        end
        tick();
        tests_run++;
        if (b.err_len0 !== 1'b0 || b.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL len0_one_cycle err=%b in_ready=%b want 0 0", b.err_len0, b.in_ready);
        end
    endtask

    task automatic test_rst_mid();
        start_frame(16'd4);
        beat(32'd3, 32'd3);
        b.in_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b.in_valid = 1'b0;
        tests_run++;
        if ({b.in_ready, b.out_valid, b.busy, b.err_len0} !== 4'b0000 || b.out_data !== 40'd0) begin
            tests_failed++;
            $display("FAIL rst_mid flags=%b out_data=%0d want 0000 0", {b.in_ready, b.out_valid, b.busy, b.err_len0}, b.out_data);
        end
        start_frame(16'd1);
        beat(32'd9, 32'd1);
        tick();
        tests_run++;
        if (b.out_valid !== 1'b1 || b.out_data !== 40'd10) begin
            tests_failed++;
            $display("FAIL rst_fresh_frame out_valid=%b out_data=%0d want 1 10", b.out_valid, b.out_data);
        end
        b.out_ready = 1'b1;
        tick();
        b.out_ready = 1'b0;
    endtask

    task automatic test_abort();
        int seen;
        seen = 0;
        start_frame(16'd4);
        beat(32'd100, 32'd200);
        beat(32'd100, 32'd200);
        b.abort = 1'b1;
        b.in_valid = 1'b1;
        tick();
        b.abort = 1'b0;
        b.in_valid = 1'b0;
        tests_run++;
        if (b.busy !== 1'b0 || b.in_ready !== 1'b0 || b.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_idle busy=%b in_ready=%b out_valid=%b want 0 0 0", b.busy, b.in_ready, b.out_valid);
        end
        for (int i = 0; i < 6; i++) begin
            if (b.out_valid === 1'b1) seen++;
            tick();
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL abort_no_result out_valid_cycles=%0d want 0", seen);
        end
        start_frame(16'd1);
        beat(32'd2, 32'd3);
        tick();
        tests_run++;
        if (b.out_valid !== 1'b1 || b.out_data !== 40'd5) begin
            tests_failed++;
            $display("FAIL abort_then_frame out_valid=%b out_data=%0d want 1 5", b.out_valid, b.out_data);
        end
        b.out_ready = 1'b1;
        tick();
        b.out_ready = 1'b0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        b.start = 1'b0;     b.frame_len = '0;   b.abort = 1'b0;
        b.in_valid = 1'b0;  b.in1 = '0;         b.in2 = '0;
        b.out_ready = 1'b0;
        b33.start = 1'b0;   b33.frame_len = '0; b33.abort = 1'b0;
        b33.in_valid = 1'b0; b33.in1 = '0;      b33.in2 = '0;
        b33.out_ready = 1'b0;
        test_reset();
        test_single();
        test_gaps();
        test_wrap();
        test_backpressure();
        test_len0();
        test_rst_mid();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/accum_frame_ctrl.md
Name: accum_frame_ctrl

Overview:
Frame sequencer wrapping a cross-coupled dual accumulator datapath (acc0/acc1). Accepts a start command with a frame length and consumes exactly that many (in1, in2) sample pairs over a valid/ready stream. It then emits one frame result, acc0+acc1, over a valid/ready output. Sits between the sample source and the result consumer, and owns clear, enable and frame boundaries the raw accumulator lacks.

Parameters:
DW, 32, sample width of in1/in2 (unsigned)
AW, 40, accumulator and result width; requires AW >= DW
LW, 16, frame-length counter width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  frame start request, sampled only in IDLE
frame_len  input  LW  number of sample pairs in frame, latched with start
abort  input  1  abandon current frame (RUN/FINAL/DONE)
in_valid  input  1  sample pair valid
in_ready  output  1  block accepts sample pair
in1  input  DW  sample for acc0 path
in2  input  DW  sample for acc1 path
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts result
out_data  output  AW  frame result
busy  output  1  high in any state except IDLE
err_len0  output  1  one-cycle pulse: start with frame_len==0

Behaviour:
- Reset: state=IDLE; acc0, acc1, count, out_data = 0; in_ready=0, out_valid=0, busy=0, err_len0=0. Reset wins over every other input, including mid-frame.
- States: IDLE, RUN, FINAL, DONE.
- IDLE: in_ready=0. On start && frame_len!=0: latch len=frame_len, clear acc0=acc1=0, count=0, go to RUN.
- IDLE: on start && frame_len==0: err_len0=1 for one cycle, stay in IDLE.
- RUN: in_ready=1. Beat = in_valid && in_ready.
- Per beat: acc0 <= acc1 + in1 and acc1 <= acc0 + in2, using pre-update values. Inputs are zero-extended to AW; sums wrap mod 2^AW. count <= count+1.
- No beat: acc0, acc1 and count hold. Gaps in in_valid are legal.
- RUN exit: when the beat with count==len-1 is accepted, go to FINAL; in_ready drops the next cycle.
- FINAL: one cycle. out_data <= acc0 + acc1 mod 2^AW. Go to DONE.
- Latency: last beat accepted at cycle T gives out_valid=1 at T+2.
- DONE: out_valid=1; out_data stable until handshake. On out_ready go to IDLE; out_valid=0 the next cycle. out_ready may already be high on the first DONE cycle. out_data keeps its value after handshake.
- start outside IDLE: ignored, no error.
- abort in RUN/FINAL/DONE: go to IDLE next cycle. A beat coincident with abort is discarded. out_valid=0 next cycle. No result is emitted for the aborted frame. acc0/acc1 are cleared at the next start.
- abort coincident with the DONE handshake: the handshake completes; go to IDLE either way.
- abort in IDLE: no effect.
- Same-cycle DONE exit and start: start is not seen until the next cycle, because the state is still DONE.
- count is LW bits. The maximum frame is 2^LW-1 beats; no count overflow is possible.

Test Plan:
- len=1, in1=5, in2=7 -> acc0=5, acc1=7; out_data=12 with out_valid at T+2; busy low after handshake.
- len=3, pairs (1,2),(3,4),(5,6), with one-cycle in_valid gaps between beats -> acc0/acc1 = (1,2), (5,5), (10,11); out_data=21.
- AW=33 override, len=2, in1=in2=0xFFFFFFFF -> acc0=acc1=0x1FFFFFFFE; out_data=0x1FFFFFFFC (wrapped).
- len=2 result with out_ready held low 5 cycles -> out_valid held high and out_data stable; single handshake on release; start during DONE ignored.
- start with frame_len=0 -> err_len0 high exactly 1 cycle; state stays IDLE; in_ready stays 0.
- Mid-RUN events:
  - rst asserted after 1 of 4 beats -> all outputs 0 next cycle.
  - New len=1 frame (9,1) after the rst -> out_data=10, so no stale accumulator state.
  - abort after 2 of 4 beats -> no out_valid, IDLE next cycle.
